hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage integer pipeline. It pairs with the EXE-stage operand forwarding mux, which forwards from MEM and WB.
- It detects load-use hazards that forwarding cannot cover and inserts one bubble for each.
- It squashes wrong-path instructions on a taken branch.
- It holds the front of the pipeline while the multi-cycle multiply/divide unit in EXE runs.
- It keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- MUL_LAT, 4, total EXE occupancy in cycles of a multiply; must be ≥2
- DIV_LAT, 16, total EXE occupancy in cycles of a divide; must be ≥2

Ports:
- CLK  in  1  clock; single clock domain
- RST  in  1  synchronous, active-high reset
- RS, RT  in  5  source register addresses of the instruction in ID
- USES_RS, USES_RT  in  1  ID instruction reads RS / RT (RT includes store data)
- RD_ADD_EXE  in  5  destination address of the instruction in EXE
- WB_EN_EXE  in  1  EXE instruction writes back
- MEM_R_EN_EXE  in  1  EXE instruction is a load
- BR_TAKEN  in  1  EXE resolved a taken branch or jump this cycle
- MD_EXE  in  1  EXE holds a multiply/divide
- MD_IS_DIV  in  1  qualifies MD_EXE: 1 = divide, 0 = multiply
- PC_WR_EN  out  1  PC register write enable
- IF_ID_WR_EN  out  1  IF/ID register write enable
- IF_ID_FLUSH  out  1  load NOP into IF/ID
- ID_EXE_BUBBLE  out  1  load NOP into ID/EXE
- ID_EXE_HOLD  out  1  ID/EXE register keeps its contents
- EXE_MEM_BUBBLE  out  1  load NOP into EXE/MEM
- MD_DONE  out  1  the multiply/divide result is valid in EXE this cycle
- STALL_CNT  out  16  saturating count of stalled cycles

## Operation
- FSM states:
  - RUN: normal flow.
  - MD_WAIT: a multiply/divide is occupying EXE.
  - Down-counter `cnt` is 5 bits.
- Load-use hazard, combinational, evaluated only in RUN:
  - LD_HAZ = MEM_R_EN_EXE & WB_EN_EXE & (RD_ADD_EXE≠0) & ((USES_RS & RS==RD_ADD_EXE) | (USES_RT & RT==RD_ADD_EXE)).
  - LD_HAZ=1 → PC_WR_EN=0, IF_ID_WR_EN=0, ID_EXE_BUBBLE=1, for one cycle.
  - In the next cycle the load is in MEM and the forwarding path covers the dependency. No state is kept.
- Taken branch (RUN, BR_TAKEN=1):
  - Outputs: IF_ID_FLUSH=1, ID_EXE_BUBBLE=1, PC_WR_EN=1 (PC takes the target), IF_ID_WR_EN=1.
  - BR_TAKEN overrides LD_HAZ, because the ID instruction is wrong-path.
- Multiply/divide start (RUN, MD_EXE=1):
  - LAT = DIV_LAT if MD_IS_DIV, else MUL_LAT.
  - In this cycle: PC_WR_EN=0, IF_ID_WR_EN=0, ID_EXE_HOLD=1, EXE_MEM_BUBBLE=1.
  - Load cnt=LAT-2 and go to MD_WAIT.
  - MD_EXE has priority over LD_HAZ; no ID_EXE_BUBBLE is issued.
- MD_WAIT:
  - cnt≠0: same hold outputs as the start cycle; cnt decrements.
  - cnt==0: all holds drop, MD_DONE=1, next state is RUN.
  - MD_EXE and MD_IS_DIV are ignored in MD_WAIT. MD_EXE is still 1 in the MD_DONE cycle and does not retrigger.
  - BR_TAKEN is ignored in MD_WAIT; it cannot legally occur there.
- Default outputs (no event):
  - PC_WR_EN=1, IF_ID_WR_EN=1.
  - All flush, bubble and hold outputs 0. MD_DONE=0.
- STALL_CNT increments by 1 on every non-reset cycle with PC_WR_EN=0. It saturates at 0xFFFF.

## Timing
- Hazard and branch outputs are combinational from the inputs in the same cycle, with zero latency.
- A multiply/divide entering EXE in cycle t:
  - Holds asserted in cycles t … t+LAT-2, i.e. exactly LAT-1 cycles.
  - MD_DONE=1 in cycle t+LAT-1 only.
  - The front end advances at the end of cycle t+LAT-1.
- LAT=2 → one hold cycle (t); MD_DONE in t+1.
- Back-to-back multiply/divides: the second enters EXE in cycle t+LAT and triggers a fresh sequence from RUN.
- While RST=1:
  - Next state RUN, cnt←0, STALL_CNT←0.
  - Outputs forced: PC_WR_EN=0, IF_ID_WR_EN=0, IF_ID_FLUSH=1, ID_EXE_BUBBLE=1, ID_EXE_HOLD=0, EXE_MEM_BUBBLE=1, MD_DONE=0.
- Reset during MD_WAIT aborts the operation with no MD_DONE. The first cycle after RST falls is in RUN.

## Test plan
- Load r5 in EXE; ID instruction reads RS=5 → one cycle with PC_WR_EN=0, IF_ID_WR_EN=0, ID_EXE_BUBBLE=1; next cycle defaults; STALL_CNT=1. Repeat with RD_ADD_EXE=0, or with WB_EN_EXE=0 → no stall.
- BR_TAKEN=1 in the same cycle as LD_HAZ → IF_ID_FLUSH=1, ID_EXE_BUBBLE=1, PC_WR_EN=1; STALL_CNT unchanged.
- MD_EXE=1, MD_IS_DIV=0, MUL_LAT=4, held high for 4 cycles → holds asserted for cycles 0–2, MD_DONE in cycle 3 only, no retrigger; STALL_CNT=3.
- Divide (DIV_LAT=16) immediately followed by a multiply in EXE at cycle 16 → 15 hold cycles + MD_DONE at cycle 15; then 3 hold cycles + MD_DONE at cycle 19; STALL_CNT=18.
- RST asserted at cycle 5 of a divide → forced reset outputs that cycle, STALL_CNT=0, no MD_DONE; after RST falls the FSM is in RUN with defaults.
- Preload STALL_CNT to 0xFFFE via 65534 load stalls, then 3 more stalls → STALL_CNT=0xFFFF, no wrap.

Source files
------------

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: groups the hazard controller's pipeline-side inputs and control outputs.
//   master modport: drives ID/EXE status (RS, RT, USES_*, RD_ADD_EXE, WB_EN_EXE, MEM_R_EN_EXE,
//                   BR_TAKEN, MD_EXE, MD_IS_DIV) and observes the control outputs.
//   slave modport:  the controller itself; consumes status and drives PC_WR_EN, IF_ID_WR_EN,
//                   IF_ID_FLUSH, ID_EXE_BUBBLE, ID_EXE_HOLD, EXE_MEM_BUBBLE, MD_DONE, STALL_CNT.
interface hazard_controller_if;
    logic [4:0]  RS;
    logic [4:0]  RT;
    logic        USES_RS;
    logic        USES_RT;
    logic [4:0]  RD_ADD_EXE;
    logic        WB_EN_EXE;
    logic        MEM_R_EN_EXE;
    logic        BR_TAKEN;
    logic        MD_EXE;
    logic        MD_IS_DIV;

    logic        PC_WR_EN;
    logic        IF_ID_WR_EN;
    logic        IF_ID_FLUSH;
    logic        ID_EXE_BUBBLE;
    logic        ID_EXE_HOLD;
    logic        EXE_MEM_BUBBLE;
    logic        MD_DONE;
    logic [15:0] STALL_CNT;

    modport master (
        output RS, RT, USES_RS, USES_RT, RD_ADD_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               BR_TAKEN, MD_EXE, MD_IS_DIV,
        input  PC_WR_EN, IF_ID_WR_EN, IF_ID_FLUSH, ID_EXE_BUBBLE, ID_EXE_HOLD,
               EXE_MEM_BUBBLE, MD_DONE, STALL_CNT
    );

    modport slave (
        input  RS, RT, USES_RS, USES_RT, RD_ADD_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               BR_TAKEN, MD_EXE, MD_IS_DIV,
        output PC_WR_EN, IF_ID_WR_EN, IF_ID_FLUSH, ID_EXE_BUBBLE, ID_EXE_HOLD,
               EXE_MEM_BUBBLE, MD_DONE, STALL_CNT
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, taken-branch squash and multiply/divide hold sequencer for
// the 5-stage pipeline, plus a saturating stalled-cycle counter.
//   CLK, RST : clock and synchronous active-high reset
//   hz       : hazard_controller_if.slave (ID/EXE status in, pipeline register controls out)
//   MUL_LAT / DIV_LAT : total EXE occupancy of a multiply / divide, each in 2..32
module hazard_controller #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16
) (
    input logic              CLK,
    input logic              RST,
    hazard_controller_if.slave hz
);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    // The start cycle is one hold cycle, the done cycle is the last, hence LAT-2 extra holds.
    localparam logic [4:0] MulCnt = 5'(MUL_LAT - 2);
    localparam logic [4:0] DivCnt = 5'(DIV_LAT - 2);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q;

    logic ld_haz;
    logic pc_wr_en, if_id_wr_en, if_id_flush, id_exe_bubble, id_exe_hold;
    logic exe_mem_bubble, md_done;

    // A load in EXE whose result the ID instruction needs cannot be forwarded yet.
    assign ld_haz = hz.MEM_R_EN_EXE & hz.WB_EN_EXE & (hz.RD_ADD_EXE != 5'd0) &
                    ((hz.USES_RS & (hz.RS == hz.RD_ADD_EXE)) |
                     (hz.USES_RT & (hz.RT == hz.RD_ADD_EXE)));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_wr_en       = 1'b1;
        if_id_wr_en    = 1'b1;
        if_id_flush    = 1'b0;
        id_exe_bubble  = 1'b0;
        id_exe_hold    = 1'b0;
        exe_mem_bubble = 1'b0;
        md_done        = 1'b0;

        if (RST) begin
            state_d        = StRun;
            cnt_d          = 5'd0;
            pc_wr_en       = 1'b0;
            if_id_wr_en    = 1'b0;
            if_id_flush    = 1'b1;
            id_exe_bubble  = 1'b1;
            exe_mem_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hz.BR_TAKEN) begin
                        // ID holds a wrong-path instruction, so any load-use stall is moot.
                        if_id_flush   = 1'b1;
                        id_exe_bubble = 1'b1;
                    end else if (hz.MD_EXE) begin
                        pc_wr_en       = 1'b0;
                        if_id_wr_en    = 1'b0;
                        id_exe_hold    = 1'b1;
                        exe_mem_bubble = 1'b1;
                        cnt_d          = hz.MD_IS_DIV ? DivCnt : MulCnt;
                        state_d        = StMdWait;
                    end else if (ld_haz) begin
                        pc_wr_en      = 1'b0;
                        if_id_wr_en   = 1'b0;
                        id_exe_bubble = 1'b1;
                    end
                end
                StMdWait: begin
                    if (cnt_q != 5'd0) begin
                        pc_wr_en       = 1'b0;
                        if_id_wr_en    = 1'b0;
                        id_exe_hold    = 1'b1;
                        exe_mem_bubble = 1'b1;
                        cnt_d          = cnt_q - 5'd1;
                    end else begin
                        // MD_EXE is still high here; returning to RUN without a start is intended.
                        md_done = 1'b1;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StRun;
            cnt_q       <= 5'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_wr_en && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign hz.PC_WR_EN       = pc_wr_en;
    assign hz.IF_ID_WR_EN    = if_id_wr_en;
    assign hz.IF_ID_FLUSH    = if_id_flush;
    assign hz.ID_EXE_BUBBLE  = id_exe_bubble;
    assign hz.ID_EXE_HOLD    = id_exe_hold;
    assign hz.EXE_MEM_BUBBLE = exe_mem_bubble;
    assign hz.MD_DONE        = md_done;
    assign hz.STALL_CNT      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios with literal expectations plus randomized traffic,
// all cycles also checked against a cycle-phase reference model of the controller.
module tb_hazard_controller;

    localparam int unsigned MulLat = 4;
    localparam int unsigned DivLat = 16;

    logic CLK;
    logic RST;
    hazard_controller_if bus ();

    hazard_controller #(
        .MUL_LAT (MulLat),
        .DIV_LAT (DivLat)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a multiply/divide occupies EXE for phases 0..lat-1 counted from its start
    // cycle; phases 0..lat-2 stall, phase lat-1 reports done.
    bit m_busy  = 1'b0;
    int m_phase = 0;
    int m_lat   = 0;
    int m_stall = 0;

    always @(negedge CLK) begin
        if (cmp_en) begin
            bit haz;
            bit e_pc, e_ifid, e_flush, e_bub, e_hold, e_emb, e_done;
            haz = bus.MEM_R_EN_EXE && bus.WB_EN_EXE && (bus.RD_ADD_EXE != 0) &&
                  ((bus.USES_RS && bus.RS == bus.RD_ADD_EXE) ||
                   (bus.USES_RT && bus.RT == bus.RD_ADD_EXE));
            {e_pc, e_ifid, e_flush, e_bub, e_hold, e_emb, e_done} = 7'b1100000;
            if (RST) begin
                {e_pc, e_ifid, e_flush, e_bub, e_hold, e_emb, e_done} = 7'b0011010;
            end else if (m_busy) begin
                if (m_phase < m_lat - 1) {e_pc, e_ifid, e_hold, e_emb} = 4'b0011;
                else                     e_done = 1'b1;
            end else if (bus.BR_TAKEN) begin
                {e_flush, e_bub} = 2'b11;
            end else if (bus.MD_EXE) begin
                {e_pc, e_ifid, e_hold, e_emb} = 4'b0011;
            end else if (haz) begin
                {e_pc, e_ifid, e_bub} = 3'b001;
            end
            chk("pc_wr_en",       32'(bus.PC_WR_EN),       32'(e_pc));
            chk("if_id_wr_en",    32'(bus.IF_ID_WR_EN),    32'(e_ifid));
            chk("if_id_flush",    32'(bus.IF_ID_FLUSH),    32'(e_flush));
            chk("id_exe_bubble",  32'(bus.ID_EXE_BUBBLE),  32'(e_bub));
            chk("id_exe_hold",    32'(bus.ID_EXE_HOLD),    32'(e_hold));
            chk("exe_mem_bubble", 32'(bus.EXE_MEM_BUBBLE), 32'(e_emb));
            chk("md_done",        32'(bus.MD_DONE),        32'(e_done));
            chk("stall_cnt",      32'(bus.STALL_CNT),      32'(m_stall));

            // Advance the model to the next cycle.
            if (RST) begin
                m_busy  = 1'b0;
                m_stall = 0;
            end else begin
                if (!e_pc) m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
                if (m_busy) begin
                    m_phase++;
                    if (m_phase >= m_lat) m_busy = 1'b0;
                end else if (!bus.BR_TAKEN && bus.MD_EXE) begin
                    m_busy  = 1'b1;
                    m_phase = 1;
                    m_lat   = bus.MD_IS_DIV ? DivLat : MulLat;
                end
            end
        end
    end

    task automatic drive(input int rs, input int rt, input bit urs, input bit urt, input int rd,
                         input bit wb, input bit mr, input bit br, input bit md, input bit dv);
        bus.RS = 5'(rs);  bus.RT = 5'(rt);  bus.USES_RS = urs;  bus.USES_RT = urt;
        bus.RD_ADD_EXE = 5'(rd);  bus.WB_EN_EXE = wb;  bus.MEM_R_EN_EXE = mr;
        bus.BR_TAKEN = br;  bus.MD_EXE = md;  bus.MD_IS_DIV = dv;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance to the next cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Let outputs settle after a drive before a literal check.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        step();
        RST = 1'b0;
    endtask

    initial begin
        int holds;
        RST = 1'b1;
        idle();
        step();
        cmp_en = 1'b1;

        // Reset cycle outputs.
        settle();
        chk("rst pc_wr_en", 32'(bus.PC_WR_EN), 32'd0);
        chk("rst if_id_flush", 32'(bus.IF_ID_FLUSH), 32'd1);
        chk("rst exe_mem_bubble", 32'(bus.EXE_MEM_BUBBLE), 32'd1);
        step();
        RST = 1'b0;
        chk("rst stall_cnt", 32'(bus.STALL_CNT), 32'd0);

        // Load-use on RS, then defaults.
        drive(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        settle();
        chk("ldhaz pc_wr_en", 32'(bus.PC_WR_EN), 32'd0);
        chk("ldhaz bubble", 32'(bus.ID_EXE_BUBBLE), 32'd1);
        step();
        idle();
        settle();
        chk("after ldhaz pc_wr_en", 32'(bus.PC_WR_EN), 32'd1);
        chk("after ldhaz stall_cnt", 32'(bus.STALL_CNT), 32'd1);
        step();
        drive(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        settle();
        chk("rd0 no stall", 32'(bus.PC_WR_EN), 32'd1);
        step();
        drive(5, 0, 1, 0, 5, 0, 1, 0, 0, 0);
        settle();
        chk("no wb no stall", 32'(bus.PC_WR_EN), 32'd1);
        step();

        // Branch overrides a simultaneous load-use.
        drive(0, 7, 0, 1, 7, 1, 1, 1, 0, 0);
        settle();
        chk("br flush", 32'(bus.IF_ID_FLUSH), 32'd1);
        chk("br pc_wr_en", 32'(bus.PC_WR_EN), 32'd1);
        step();
        idle();
        chk("br stall_cnt", 32'(bus.STALL_CNT), 32'd1);

        // Multiply held high for its full occupancy.
        do_reset();
        holds = 0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            settle();
            holds += int'(bus.ID_EXE_HOLD);
            if (c == 3) chk("mul done c3", 32'(bus.MD_DONE), 32'd1);
            step();
        end
        idle();
        chk("mul holds", 32'(holds), 32'd3);
        chk("mul stall_cnt", 32'(bus.STALL_CNT), 32'd3);

        // Divide immediately followed by a multiply.
        do_reset();
        holds = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, (c < 16) ? 1'b1 : 1'b0);
            settle();
            holds += int'(bus.ID_EXE_HOLD);
            if (c == 15) chk("div done c15", 32'(bus.MD_DONE), 32'd1);
            if (c == 19) chk("mul done c19", 32'(bus.MD_DONE), 32'd1);
            step();
        end
        idle();
        chk("div+mul holds", 32'(holds), 32'd18);
        chk("div+mul stall_cnt", 32'(bus.STALL_CNT), 32'd18);

        // Reset in cycle 5 of a divide aborts it.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            step();
        end
        RST = 1'b1;
        settle();
        chk("abort md_done", 32'(bus.MD_DONE), 32'd0);
        chk("abort pc_wr_en", 32'(bus.PC_WR_EN), 32'd0);
        chk("abort hold", 32'(bus.ID_EXE_HOLD), 32'd0);
        step();
        RST = 1'b0;
        idle();
        settle();
        chk("post abort pc_wr_en", 32'(bus.PC_WR_EN), 32'd1);
        chk("post abort md_done", 32'(bus.MD_DONE), 32'd0);
        chk("post abort stall_cnt", 32'(bus.STALL_CNT), 32'd0);
        step();

        // Saturation of the stall counter.
        do_reset();
        drive(0, 9, 0, 1, 9, 1, 1, 0, 0, 0);
        repeat (65534) step();
        chk("stall_cnt preload", 32'(bus.STALL_CNT), 32'hFFFE);
        repeat (3) step();
        idle();
        chk("stall_cnt saturate", 32'(bus.STALL_CNT), 32'hFFFF);
        step();

        // Randomized traffic; small register range to provoke matches.
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(63) == 0);
            drive($urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
                  $urandom_range(3), 1'($urandom), 1'($urandom),
                  ($urandom_range(7) == 0), ($urandom_range(11) == 0), 1'($urandom));
            step();
        end
        RST = 1'b0;
        idle();
        step();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
